mem_access: RTL and testbench

//  MEM-stage data-memory access controller. Sits between the EX/MEM and MEM/WB pipeline registers.

---
 rtl/mem_access_pkg.sv | 19 +
 rtl/mem_access_wdog.sv | 38 +++
 rtl/mem_access.sv | 143 ++++++++++++++
 tb/tb_mem_access.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller:
// FSM state encoding, abort read-data default and the word-address helper.
package mem_access_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2,
      ST_ERR  = 2'd3
   } state_e;

   localparam logic [31:0] ERR_RDATA_DEF = 32'hDEADBEEF;
   localparam int          WDOG_W        = 8;

   function automatic logic [31:0] word_addr(input logic [31:0] a);
      return a & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/mem_access_wdog.sv
// Watchdog counter: clears on request, counts while enabled, flags the last
// allowed cycle so the owner can abort on the same edge.
module mem_access_wdog
   import mem_access_pkg::*;
#(
   parameter int unsigned LIMIT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam logic [WDOG_W-1:0] LAST = WDOG_W'(LIMIT - 1);

   logic [WDOG_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = (cnt_q == LAST);

endmodule

// File: rtl/mem_access.sv
// MEM-stage data-memory access controller: req/ack bus handshake, pipeline
// stall, timeout abort and branch resolve. Optional macro MISALIGN_TRAP_EN.
module mem_access
   import mem_access_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 16,
   parameter logic [31:0] ERR_RDATA   = ERR_RDATA_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        MEM_Branch,
   input  logic        MEM_zero,
   input  logic        MEM_MemRead,
   input  logic        MEM_MemWrite,
   input  logic [31:0] MEM_ALU_res,
   input  logic [31:0] MEM_rdata2,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        PCSrc,
   output logic        mem_stall,
   output logic [31:0] MEM_rdata,
   output logic        mem_err,
   output logic        mem_misalign
);

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        we_q, we_d;
   logic        mis_q, mis_d;
   logic        access, start, trap, in_req, expire;

   assign access = MEM_MemRead | MEM_MemWrite;
   assign start  = (state_q == ST_IDLE) && access;
   assign in_req = (state_q == ST_REQ);

`ifdef MISALIGN_TRAP_EN
   assign trap = start && (MEM_ALU_res[1:0] != 2'b00);
`else
   assign trap = 1'b0;
`endif

   // Branch resolve is independent of the stall; the upstream freeze gates it.
   assign PCSrc = MEM_Branch & MEM_zero;

   mem_access_wdog #(
      .LIMIT (TIMEOUT_CYC)
   ) u_wdog (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (start),
      .en     (in_req),
      .expire (expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (trap) begin
               state_d = ST_ERR;
            end else if (access) begin
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (dmem_ack) begin
               state_d = ST_DONE;
            end else if (expire) begin
               state_d = ST_ERR;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      dmem_req     = in_req;
      mem_stall    = start | in_req;
      mem_err      = (state_q == ST_ERR);
      mem_misalign = mis_q;
   end

   // Bus-side registers hold steady for the whole REQ window; an ack wins over expiry.
   always_comb begin
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      rdata_d = rdata_q;
      mis_d   = trap;
      if (start) begin
         addr_d  = word_addr(MEM_ALU_res);
         wdata_d = MEM_rdata2;
         we_d    = MEM_MemWrite;
      end
      if (trap) begin
         rdata_d = ERR_RDATA;
      end else if (in_req && dmem_ack) begin
         if (!we_q) begin
            rdata_d = dmem_rdata;
         end
      end else if (in_req && expire) begin
         rdata_d = ERR_RDATA;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         rdata_q <= '0;
         mis_q   <= 1'b0;
      end else begin
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         rdata_q <= rdata_d;
         mis_q   <= mis_d;
      end
   end

   assign dmem_addr  = addr_q;
   assign dmem_wdata = wdata_q;
   assign dmem_we    = we_q;
   assign MEM_rdata  = rdata_q;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed vector table, reset/branch sequences and
// randomized accesses against a transaction-level reference model.
module tb_mem_access;

   localparam int TO_A = 16;
   localparam int TO_B = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        MEM_Branch, MEM_zero, MEM_MemRead, MEM_MemWrite;
   logic [31:0] MEM_ALU_res, MEM_rdata2, dmem_rdata;
   logic        dmem_ack;
   logic        sel16;

   logic        req_a, we_a, pc_a, st_a, err_a, mis_a;
   logic [31:0] addr_a, wd_a, rd_a;
   logic        req_b, we_b, pc_b, st_b, err_b, mis_b;
   logic [31:0] addr_b, wd_b, rd_b;

   logic        o_req, o_we, o_pc, o_stall, o_err, o_mis;
   logic [31:0] o_addr, o_wdata, o_rdata;

   int checks   = 0;
   int failures = 0;
   logic [31:0] model_rdata;

   always #5 clk = ~clk;

   mem_access #(.TIMEOUT_CYC(TO_A)) dut_a (
      .clk(clk), .rst_n(rst_n), .MEM_Branch(MEM_Branch), .MEM_zero(MEM_zero),
      .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
      .MEM_ALU_res(MEM_ALU_res), .MEM_rdata2(MEM_rdata2),
      .dmem_req(req_a), .dmem_we(we_a), .dmem_addr(addr_a), .dmem_wdata(wd_a),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .PCSrc(pc_a),
      .mem_stall(st_a), .MEM_rdata(rd_a), .mem_err(err_a), .mem_misalign(mis_a));

   mem_access #(.TIMEOUT_CYC(TO_B)) dut_b (
      .clk(clk), .rst_n(rst_n), .MEM_Branch(MEM_Branch), .MEM_zero(MEM_zero),
      .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
      .MEM_ALU_res(MEM_ALU_res), .MEM_rdata2(MEM_rdata2),
      .dmem_req(req_b), .dmem_we(we_b), .dmem_addr(addr_b), .dmem_wdata(wd_b),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .PCSrc(pc_b),
      .mem_stall(st_b), .MEM_rdata(rd_b), .mem_err(err_b), .mem_misalign(mis_b));

   assign o_req   = sel16 ? req_a  : req_b;
   assign o_we    = sel16 ? we_a   : we_b;
   assign o_pc    = sel16 ? pc_a   : pc_b;
   assign o_stall = sel16 ? st_a   : st_b;
   assign o_err   = sel16 ? err_a  : err_b;
   assign o_mis   = sel16 ? mis_a  : mis_b;
   assign o_addr  = sel16 ? addr_a : addr_b;
   assign o_wdata = sel16 ? wd_a   : wd_b;
   assign o_rdata = sel16 ? rd_a   : rd_b;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] bus_rdata;
      int          lat;
      int          exp_stall;
      int          exp_req;
      logic [31:0] exp_rdata;
      logic        exp_err;
      logic        exp_mis;
      logic [31:0] exp_addr;
      logic        exp_we;
      string       nm;
   } vec_t;

   vec_t tbl[7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Transaction-level expectation from the access rules.
   function automatic vec_t model(input logic rd, input logic wr, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] bus,
                                  input int lat, input int to, input logic [31:0] prev);
      vec_t v;
      logic served;
      logic trapped;
      v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.bus_rdata = bus;
      v.lat = lat; v.nm = "rand";
      v.exp_addr = addr & 32'hFFFF_FFFC;
      v.exp_we   = wr;
`ifdef MISALIGN_TRAP_EN
      trapped = (addr[1:0] != 2'b00);
`else
      trapped = 1'b0;
`endif
      if (trapped) begin
         v.exp_stall = 1; v.exp_req = 0; v.exp_err = 1'b1; v.exp_mis = 1'b1;
         v.exp_rdata = 32'hDEADBEEF;
      end else begin
         served      = (lat >= 1) && (lat <= to);
         v.exp_req   = served ? lat : to;
         v.exp_stall = v.exp_req + 1;
         v.exp_err   = !served;
         v.exp_mis   = 1'b0;
         v.exp_rdata = !served ? 32'hDEADBEEF : (wr ? prev : bus);
      end
      return v;
   endfunction

   task automatic run_access(input vec_t v);
      int stall_n = 0;
      int req_n   = 0;
      bit done    = 0;
      bit early   = 0;
      bit unstab  = 0;
      MEM_MemRead  = v.rd;
      MEM_MemWrite = v.wr;
      MEM_ALU_res  = v.addr;
      MEM_rdata2   = v.wdata;
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
         @(negedge clk);
         if (o_stall) begin
            stall_n++;
            if (o_err) early = 1;
            if (o_req) begin
               req_n++;
               if (o_addr !== v.exp_addr || o_we !== v.exp_we ||
                   (v.exp_we && o_wdata !== v.wdata)) unstab = 1;
               dmem_ack   = (req_n == v.lat);
               dmem_rdata = (req_n == v.lat) ? v.bus_rdata : $urandom;
            end
         end else begin
            done = 1;
            chk({v.nm, "_err"},   32'(o_err),   32'(v.exp_err));
            chk({v.nm, "_mis"},   32'(o_mis),   32'(v.exp_mis));
            chk({v.nm, "_rdata"}, o_rdata,      v.exp_rdata);
            chk({v.nm, "_reqlo"}, 32'(o_req),   32'd0);
         end
         @(posedge clk); #1;
         dmem_ack = 1'b0;
      end
      if (!done) chk({v.nm, "_finished"}, 32'd0, 32'd1);
      chk({v.nm, "_stall_cycles"}, 32'(stall_n), 32'(v.exp_stall));
      chk({v.nm, "_req_cycles"},   32'(req_n),   32'(v.exp_req));
      chk({v.nm, "_no_early_err"}, 32'(early),   32'd0);
      chk({v.nm, "_bus_stable"},   32'(unstab),  32'd0);
      MEM_MemRead  = 1'b0;
      MEM_MemWrite = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0; MEM_Branch = 1'b0; MEM_zero = 1'b0;
      dmem_ack = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench watchdog expired");
   end

   initial begin
      rst_n = 1'b0; sel16 = 1'b1;
      MEM_Branch = 1'b0; MEM_zero = 1'b0; MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0;
      MEM_ALU_res = '0; MEM_rdata2 = '0; dmem_ack = 1'b0; dmem_rdata = '0;
      model_rdata = '0;

      tbl[0] = '{1'b1, 1'b0, 32'h100, 32'h0, 32'h12345678, 1, 2, 1, 32'h12345678,
                 1'b0, 1'b0, 32'h100, 1'b0, "load_ack1"};
      tbl[1] = '{1'b0, 1'b1, 32'h200, 32'hCAFEF00D, 32'h0, 5, 6, 5, 32'h12345678,
                 1'b0, 1'b0, 32'h200, 1'b1, "store_ack5"};
      tbl[2] = '{1'b1, 1'b1, 32'h300, 32'h11112222, 32'h99999999, 3, 4, 3, 32'h12345678,
                 1'b0, 1'b0, 32'h300, 1'b1, "rdwr_as_write"};
`ifdef MISALIGN_TRAP_EN
      tbl[3] = '{1'b1, 1'b0, 32'h102, 32'h0, 32'hA5A50102, 2, 1, 0, 32'hDEADBEEF,
                 1'b1, 1'b1, 32'h100, 1'b0, "misalign"};
`else
      tbl[3] = '{1'b1, 1'b0, 32'h102, 32'h0, 32'hA5A50102, 2, 3, 2, 32'hA5A50102,
                 1'b0, 1'b0, 32'h100, 1'b0, "misalign"};
`endif
      tbl[4] = '{1'b1, 1'b0, 32'h400, 32'h0, 32'h0, 0, 5, 4, 32'hDEADBEEF,
                 1'b1, 1'b0, 32'h400, 1'b0, "load_timeout"};
      tbl[5] = '{1'b1, 1'b0, 32'h404, 32'h0, 32'h0BADF00D, 4, 5, 4, 32'h0BADF00D,
                 1'b0, 1'b0, 32'h404, 1'b0, "ack_wins"};
      tbl[6] = '{1'b0, 1'b1, 32'h408, 32'h55AA55AA, 32'h0, 0, 5, 4, 32'hDEADBEEF,
                 1'b1, 1'b0, 32'h408, 1'b1, "store_timeout"};

      // Reset values on both instances
      repeat (2) @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         sel16 = s[0];
         #1;
         chk("rst_req",   32'(o_req),   32'd0);
         chk("rst_we",    32'(o_we),    32'd0);
         chk("rst_stall", 32'(o_stall), 32'd0);
         chk("rst_err",   32'(o_err),   32'd0);
         chk("rst_mis",   32'(o_mis),   32'd0);
         chk("rst_addr",  o_addr,       32'd0);
         chk("rst_wdata", o_wdata,      32'd0);
         chk("rst_rdata", o_rdata,      32'd0);
      end
      sel16 = 1'b1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Branch with no memory op, plus a spurious ack in IDLE
      MEM_Branch = 1'b1; MEM_zero = 1'b1;
      #1;
      chk("br_pcsrc", 32'(o_pc),    32'd1);
      chk("br_stall", 32'(o_stall), 32'd0);
      @(negedge clk);
      dmem_ack = 1'b1; dmem_rdata = 32'hBAD0BAD0;
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      @(negedge clk);
      chk("spur_req",   32'(o_req),   32'd0);
      chk("spur_stall", 32'(o_stall), 32'd0);
      chk("spur_rdata", o_rdata,      32'd0);
      MEM_zero = 1'b0;
      #1;
      chk("br_nz_pcsrc", 32'(o_pc), 32'd0);
      MEM_Branch = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 4; i++) run_access(tbl[i]);

      // Reset two cycles into REQ, then a late ack
      MEM_MemRead = 1'b1; MEM_ALU_res = 32'h500;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("mid_pre_req", 32'(o_req), 32'd1);
      rst_n = 1'b0; MEM_MemRead = 1'b0;
      #1;
      chk("mid_req_drop",   32'(o_req),   32'd0);
      chk("mid_stall_drop", 32'(o_stall), 32'd0);
      chk("mid_rdata_clr",  o_rdata,      32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      dmem_ack = 1'b1; dmem_rdata = 32'h77777777;
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      @(negedge clk);
      chk("late_ack_req",   32'(o_req),   32'd0);
      chk("late_ack_stall", 32'(o_stall), 32'd0);
      chk("late_ack_rdata", o_rdata,      32'd0);
      chk("late_ack_err",   32'(o_err),   32'd0);
      @(posedge clk); #1;

      // Short-timeout instance
      sel16 = 1'b0;
      do_reset();
      for (int i = 4; i < 7; i++) run_access(tbl[i]);
      model_rdata = tbl[6].exp_rdata;

      for (int k = 0; k < 40; k++) begin
         logic        r, w, b, z;
         int          lat;
         logic [31:0] a, d, bus;
         vec_t        v;
         r = 1'($urandom_range(0, 1));
         w = 1'($urandom_range(0, 1));
         b = 1'($urandom_range(0, 1));
         z = 1'($urandom_range(0, 1));
         lat = int'($urandom_range(0, 6));
         a = $urandom; d = $urandom; bus = $urandom;
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         MEM_Branch = b; MEM_zero = z;
         #1;
         chk("rand_pcsrc", 32'(o_pc), 32'(b & z));
         if (!(r | w)) begin
            dmem_ack = 1'b1; dmem_rdata = bus;
            @(negedge clk);
            chk("rand_idle_stall", 32'(o_stall), 32'd0);
            chk("rand_idle_req",   32'(o_req),   32'd0);
            @(posedge clk); #1;
            dmem_ack = 1'b0;
            chk("rand_idle_rdata", o_rdata, model_rdata);
         end else begin
            v = model(r, w, a, d, bus, lat, TO_B, model_rdata);
            run_access(v);
            model_rdata = v.exp_rdata;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
